// File: rtl/sampler_sched_pkg.sv
// Shared types for the sampler feed scheduler.
// The FSM encoding and the issue counter width are defined here.
package sampler_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        GAP
    } state_t;

    localparam int ISSUE_CNT_W = 16;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Grants the first set request at or after the pointer, wrapping at NUM_REQ.
module rr_pick #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [ID_W-1:0]    o_idx,
    output logic               o_any
);

    int w_dist;
    int w_best;

    // Distance from the pointer decides priority; the smallest wins.
    always_comb begin
        o_gnt  = '0;
        o_idx  = '0;
        o_any  = 1'b0;
        w_best = NUM_REQ;
        w_dist = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_dist = (k + NUM_REQ - int'(i_ptr)) % NUM_REQ;
            if (i_req[k] && (w_dist < w_best)) begin
                w_best = w_dist;
                o_idx  = ID_W'(k);
                o_any  = 1'b1;
            end
        end
        if (o_any) begin
            o_gnt[o_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/sampler_feed_sched.sv
// Round-robin feed into data_sampler: one word per grant, single-cycle
// valid pulse, then a programmable idle gap for the slow-domain sampler.
module sampler_feed_sched
    import sampler_sched_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int DATA_W  = 64,
    parameter  int GAP_W   = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable_i,
    input  logic [GAP_W-1:0]          gap_cfg_i,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic [DATA_W-1:0]         data_o,
    output logic                      valid_o,
    output logic [ID_W-1:0]           src_id_o,
    output logic                      busy_o,
    output logic [ISSUE_CNT_W-1:0]    issue_cnt_o
);

    state_t                 r_state;
    state_t                 w_next;
    logic [ID_W-1:0]        r_ptr;
    logic [GAP_W-1:0]       r_gap_cnt;
    logic [DATA_W-1:0]      r_data;
    logic [ID_W-1:0]        r_src;
    logic [ISSUE_CNT_W-1:0] r_issue_cnt;

    logic [NUM_REQ-1:0]     w_gnt;
    logic [ID_W-1:0]        w_idx;
    logic                   w_any;
    logic                   w_accept;
    logic [ID_W-1:0]        w_ptr_next;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .i_req (req_valid_i),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (enable_i && w_any) begin
                    w_accept = 1'b1;
                    w_next   = ISSUE;
                end
            end
            ISSUE: begin
                w_next = (r_gap_cnt == '0) ? IDLE : GAP;
            end
            GAP: begin
                if (r_gap_cnt == GAP_W'(1)) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign w_ptr_next = (w_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;

    // Ready is masked by rst so nothing is accepted while reset is held.
    assign req_ready_o = (w_accept && !rst) ? w_gnt : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_gap_cnt   <= '0;
            r_data      <= '0;
            r_src       <= '0;
            r_issue_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_data    <= req_data_i[int'(w_idx)*DATA_W +: DATA_W];
                r_src     <= w_idx;
                r_gap_cnt <= gap_cfg_i;
                r_ptr     <= w_ptr_next;
            end
            if (r_state == GAP) begin
                r_gap_cnt <= r_gap_cnt - 1'b1;
            end
            if (r_state == ISSUE) begin
                r_issue_cnt <= r_issue_cnt + 1'b1;
            end
        end
    end

    assign data_o      = r_data;
    assign valid_o     = (r_state == ISSUE);
    assign src_id_o    = r_src;
    assign busy_o      = (r_state != IDLE);
    assign issue_cnt_o = r_issue_cnt;

endmodule
